// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default fixed-point format,
// rounding-mode selectors and the complex sample type.
package fft_pkg;

    // Default Q1.15 format used by the butterfly/twiddle stages.
    localparam int FXP_WIDTH = 16;
    localparam int FXP_FRAC  = 15;

    // Rounding-mode selectors for the ROUND parameter.
    localparam int ROUND_TRUNC   = 0;  // floor (plain arithmetic shift)
    localparam int ROUND_HALF_UP = 1;  // add half an output LSB before the shift

    // Complex sample at the default datapath width.
    typedef struct packed {
        logic signed [FXP_WIDTH-1:0] re;
        logic signed [FXP_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round / shift / clamp for one component of a wide
// fixed-point result. The input is widened by one bit first so that adding
// the rounding constant can never wrap; the clamp then sees the true value.
module fxp_round_sat
    import fft_pkg::*;
#(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int FRAC  = 15,
    parameter int ROUND = ROUND_HALF_UP
) (
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y,
    output logic                    ovf
);

    localparam int EXT_W = IN_W + 1;

    // Output range limits, sign-extended to the working width.
    localparam logic signed [EXT_W-1:0] MAX_V =
        {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V =
        {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Half an output LSB when rounding, zero when truncating.
    localparam logic signed [EXT_W-1:0] RND_K =
        (ROUND == ROUND_HALF_UP) ? (EXT_W'(1) << (FRAC - 1)) : '0;

    logic signed [EXT_W-1:0] x_ext;
    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    // Round, arithmetic shift, then clamp to the output range.
    // NOTE: every output of a combinational block gets a default at the top,
    // so no path through the if/else can leave a value unassigned and infer a latch.
    always_comb begin
        x_ext   = {x[IN_W-1], x};
        rounded = x_ext + RND_K;
        shifted = rounded >>> FRAC;
        y       = shifted[OUT_W-1:0];
        ovf     = 1'b0;
        if (shifted > MAX_V) begin
            y   = MAX_V[OUT_W-1:0];
            ovf = 1'b1;
        end else if (shifted < MIN_V) begin
            y   = MIN_V[OUT_W-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_complex_mult_pipe.sv
// Three-stage pipelined signed fixed-point complex multiplier
// p = a * b, with selectable rounding, saturation, a sticky overflow flag and
// valid/ready flow control. All stages advance together on one enable, so a
// stall freezes the whole pipe (bubbles included) and nothing is lost.
module fxp_complex_mult_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH = FXP_WIDTH,
    parameter int FRAC  = FXP_FRAC,
    parameter int ROUND = ROUND_HALF_UP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] p_re,
    output logic signed [WIDTH-1:0] p_im,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam int PW = 2 * WIDTH;      // product width
    localparam int SW = 2 * WIDTH + 1;  // sum/difference width

    // Complex operand at this instance's width.
    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_w_t;

    logic en;

    // Stage 1: registered operands.
    cplx_w_t a_d, a_q;
    cplx_w_t b_d, b_q;
    logic    v1_d, v1_q;

    // Stage 2: the four partial products.
    logic signed [PW-1:0] ac_d, ac_q;
    logic signed [PW-1:0] bd_d, bd_q;
    logic signed [PW-1:0] ad_d, ad_q;
    logic signed [PW-1:0] bc_d, bc_q;
    logic                 v2_d, v2_q;

    // Stage 3: combine, round, clamp, register.
    logic signed [SW-1:0]    re_sum, im_sum;
    logic signed [WIDTH-1:0] re_sat, im_sat;
    logic                    re_clamp, im_clamp;
    logic signed [WIDTH-1:0] p_re_d, p_re_q;
    logic signed [WIDTH-1:0] p_im_d, p_im_q;
    logic                    out_valid_d, out_valid_q;
    logic                    ovf_d, ovf_q;

    // Pipe advances whenever the output slot is empty or being drained.
    always_comb begin
        en = !out_valid_q || out_ready;
    end

    assign in_ready = en;

    // Stage 1 next state: capture operands and their valid bit on advance.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        v1_d = v1_q;
        if (en) begin
            a_d.re = a_re;
            a_d.im = a_im;
            b_d.re = b_re;
            b_d.im = b_im;
            v1_d   = in_valid;
        end
    end

    // Stage 2 next state: full-precision signed partial products.
    always_comb begin
        ac_d = ac_q;
        bd_d = bd_q;
        ad_d = ad_q;
        bc_d = bc_q;
        v2_d = v2_q;
        if (en) begin
            ac_d = PW'(a_q.re) * PW'(b_q.re);
            bd_d = PW'(a_q.im) * PW'(b_q.im);
            ad_d = PW'(a_q.re) * PW'(b_q.im);
            bc_d = PW'(a_q.im) * PW'(b_q.re);
            v2_d = v1_q;
        end
    end

    // Stage 3 arithmetic: one extra bit so the difference/sum cannot wrap.
    always_comb begin
        re_sum = SW'(ac_q) - SW'(bd_q);
        im_sum = SW'(ad_q) + SW'(bc_q);
    end

    fxp_round_sat #(
        .IN_W  (SW),
        .OUT_W (WIDTH),
        .FRAC  (FRAC),
        .ROUND (ROUND)
    ) u_sat_re (
        .x   (re_sum),
        .y   (re_sat),
        .ovf (re_clamp)
    );

    fxp_round_sat #(
        .IN_W  (SW),
        .OUT_W (WIDTH),
        .FRAC  (FRAC),
        .ROUND (ROUND)
    ) u_sat_im (
        .x   (im_sum),
        .y   (im_sat),
        .ovf (im_clamp)
    );

    // Stage 3 next state: result loads only for valid samples so p holds the
    // last real result through bubbles and stalls.
    always_comb begin
        p_re_d      = p_re_q;
        p_im_d      = p_im_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                p_re_d = re_sat;
                p_im_d = im_sat;
            end
        end
    end

    // Sticky overflow: clear request first, a clamping valid sample overrides it.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (en && v2_q && (re_clamp || im_clamp)) begin
            ovf_d = 1'b1;
        end
    end

    // Control state and visible outputs: cleared asynchronously on reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            p_re_q      <= p_re_d;
            p_im_q      <= p_im_d;
            ovf_q       <= ovf_d;
        end
    end

    // Operand and product registers.
    // NOTE: these carry no reset on purpose; the valid bit beside each stage
    // decides whether its contents mean anything, so clearing them adds nothing.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        ac_q <= ac_d;
        bd_q <= bd_d;
        ad_q <= ad_d;
        bc_q <= bc_d;
    end

    assign out_valid = out_valid_q;
    assign p_re      = p_re_q;
    assign p_im      = p_im_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fxp_complex_mult_pipe.sv
// Self-checking bench for fxp_complex_mult_pipe: three instances (Q1.15 with
// rounding, Q1.15 truncating, Q1.11 with rounding) share control inputs.
`timescale 1ns/1ps
module tb_fxp_complex_mult_pipe;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, ovf_clr;
    logic signed [15:0] a_re, a_im, b_re, b_im;
    logic signed [11:0] c_re, c_im, d_re, d_im;

    logic               in_ready, out_valid, ovf;
    logic signed [15:0] p_re, p_im;
    logic               in_ready_t, out_valid_t, ovf_t;
    logic signed [15:0] p_re_t, p_im_t;
    logic               in_ready12, out_valid12, ovf12;
    logic signed [11:0] p_re12, p_im12;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fxp_complex_mult_pipe #(.WIDTH(16), .FRAC(15), .ROUND(ROUND_HALF_UP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_re(p_re), .p_im(p_im), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    fxp_complex_mult_pipe #(.WIDTH(16), .FRAC(15), .ROUND(ROUND_TRUNC)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .p_re(p_re_t), .p_im(p_im_t), .ovf(ovf_t), .ovf_clr(ovf_clr)
    );

    fxp_complex_mult_pipe #(.WIDTH(12), .FRAC(11), .ROUND(ROUND_HALF_UP)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
        .a_re(c_re), .a_im(c_im), .b_re(d_re), .b_im(d_im),
        .out_valid(out_valid12), .out_ready(out_ready),
        .p_re(p_re12), .p_im(p_im12), .ovf(ovf12), .ovf_clr(ovf_clr)
    );

    typedef struct {
        string name;
        cplx_t a, b;
        cplx_t e1;  logic o1;   // expected, round-half-up instance
        cplx_t e0;  logic o0;   // expected, truncating instance
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sx16(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint sx12(input logic [11:0] x);
        return longint'($signed(x));
    endfunction

    // Reference: round, arithmetic shift, saturate.
    function automatic longint fx_model(input longint v, input int w, input int frac,
                                        input int rnd, output bit clamp);
        longint s, maxv, minv;
        s = v;
        if (rnd != 0) s = s + (longint'(1) << (frac - 1));
        s     = s >>> frac;
        maxv  = (longint'(1) << (w - 1)) - 1;
        minv  = -(longint'(1) << (w - 1));
        clamp = 1'b0;
        if (s > maxv) begin s = maxv; clamp = 1'b1; end
        if (s < minv) begin s = minv; clamp = 1'b1; end
        return s;
    endfunction

    task automatic set_vec(input int i, input string nm,
                           input logic [15:0] ar, ai, br, bi,
                           input logic [15:0] r1, i1, input logic o1,
                           input logic [15:0] r0, i0, input logic o0);
        vecs[i].name = nm;
        vecs[i].a.re = ar;  vecs[i].a.im = ai;
        vecs[i].b.re = br;  vecs[i].b.im = bi;
        vecs[i].e1.re = r1; vecs[i].e1.im = i1; vecs[i].o1 = o1;
        vecs[i].e0.re = r0; vecs[i].e0.im = i0; vecs[i].o0 = o0;
    endtask

    // One sample with out_ready high; checks the 3-cycle latency on all instances.
    task automatic send_one(input logic signed [15:0] ar, ai, br, bi,
                            input logic signed [11:0] cr, ci, dr, di,
                            input logic clr, input string tag);
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        c_re = cr; c_im = ci; d_re = dr; d_im = di;
        in_valid = 1'b1; ovf_clr = clr; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; ovf_clr = 1'b0;
        tick();
        check({tag, "_lat2"}, 32'({out_valid, out_valid_t, out_valid12}), 32'd0);
        tick();
        check({tag, "_lat3"}, 32'({out_valid, out_valid_t, out_valid12}), 32'd7);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic signed [15:0] s_ar[8], s_ai[8], s_br[8], s_bi[8], e_re[8], e_im[8];
        logic signed [15:0] hold_re, hold_im;
        logic signed [11:0] r_cr, r_ci, r_dr, r_di, x_re, x_im;
        bit cl_re, cl_im, held, saw_stall;
        int idx, got;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        c_re = '0; c_im = '0; d_re = '0; d_im = '0;

        //        name         a_re     a_im     b_re     b_im     R1 re    R1 im    o  R0 re    R0 im    o
        set_vec(0, "half_sq",   16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h2000, 16'h0000, 0, 16'h2000, 16'h0000, 0);
        set_vec(1, "conj_half", 16'h4000, 16'h4000, 16'h4000, 16'hC000, 16'h4000, 16'h0000, 0, 16'h4000, 16'h0000, 0);
        set_vec(2, "neg1_sq",   16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1, 16'h7FFF, 16'h0000, 1);
        set_vec(3, "lsb_up",    16'h0001, 16'h0000, 16'h4000, 16'h0000, 16'h0001, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        set_vec(4, "lsb_dn",    16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0000, 0);
        set_vec(5, "rnd_ovf",   16'h7FFF, 16'h0017, 16'h7FFF, 16'hF7A7, 16'h7FFF, 16'hF7BE, 1, 16'h7FFF, 16'hF7BE, 0);
        set_vec(6, "mixed",     16'h2000, 16'h1000, 16'h1000, 16'h2000, 16'h0000, 16'h0A00, 0, 16'h0000, 16'h0A00, 0);
        set_vec(7, "neg_clamp", 16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 1, 16'h8000, 16'h0001, 1);

        // Reset state.
        #1;
        check("rst_out_valid", 32'({out_valid, out_valid_t, out_valid12}), 32'd0);
        check("rst_p_re", 32'(p_re), 32'd0);
        check("rst_p_im", 32'(p_im), 32'd0);
        check("rst_ovf", 32'({ovf, ovf_t, ovf12}), 32'd0);
        check("rst_in_ready", 32'({in_ready, in_ready_t, in_ready12}), 32'd7);
        tick();
        tick();
        rst = 1'b0;

        // Directed vector table, ovf cleared alongside each input.
        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i].a.re, vecs[i].a.im, vecs[i].b.re, vecs[i].b.im,
                     '0, '0, '0, '0, 1'b1, vecs[i].name);
            check({vecs[i].name, "_re"},    32'(p_re),   32'(vecs[i].e1.re));
            check({vecs[i].name, "_im"},    32'(p_im),   32'(vecs[i].e1.im));
            check({vecs[i].name, "_ovf"},   32'(ovf),    32'(vecs[i].o1));
            check({vecs[i].name, "_re_t"},  32'(p_re_t), 32'(vecs[i].e0.re));
            check({vecs[i].name, "_im_t"},  32'(p_im_t), 32'(vecs[i].e0.im));
            check({vecs[i].name, "_ovf_t"}, 32'(ovf_t),  32'(vecs[i].o0));
        end

        // Sticky overflow behaviour.
        send_one(16'sh8000, 16'sh0000, 16'sh8000, 16'sh0000, '0, '0, '0, '0, 1'b1, "stk_set");
        check("stk_set_ovf", 32'(ovf), 32'd1);
        send_one(16'sh4000, 16'sh0000, 16'sh4000, 16'sh0000, '0, '0, '0, '0, 1'b0, "stk_hold");
        check("stk_hold_re", 32'(p_re), 32'h2000);
        check("stk_hold_ovf", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("stk_clr_ovf", 32'(ovf), 32'd0);
        a_re = 16'sh8000; a_im = '0; b_re = 16'sh8000; b_im = '0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("set_wins_valid", 32'(out_valid), 32'd1);
        check("set_wins_ovf", 32'({ovf, ovf_t}), 32'd3);
        tick();

        // Backpressure stream: 8 random samples, out_ready low for 4 cycles.
        for (int i = 0; i < 8; i++) begin
            s_ar[i] = 16'($urandom()); s_ai[i] = 16'($urandom());
            s_br[i] = 16'($urandom()); s_bi[i] = 16'($urandom());
            e_re[i] = 16'(fx_model(sx16(s_ar[i]) * sx16(s_br[i]) - sx16(s_ai[i]) * sx16(s_bi[i]),
                                   16, 15, 1, cl_re));
            e_im[i] = 16'(fx_model(sx16(s_ar[i]) * sx16(s_bi[i]) + sx16(s_ai[i]) * sx16(s_br[i]),
                                   16, 15, 1, cl_im));
        end
        idx = 0; got = 0; held = 1'b0; saw_stall = 1'b0;
        hold_re = '0; hold_im = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 7);
            if (idx < 8) begin
                in_valid = 1'b1;
                a_re = s_ar[idx]; a_im = s_ai[idx]; b_re = s_br[idx]; b_im = s_bi[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                check("stall_hold_re", 32'(p_re), 32'(hold_re));
                check("stall_hold_im", 32'(p_im), 32'(hold_im));
            end
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                if (got < 8) begin
                    check($sformatf("stream%0d_re", got), 32'(p_re), 32'(e_re[got]));
                    check($sformatf("stream%0d_im", got), 32'(p_im), 32'(e_im[got]));
                end
                got++;
            end
            held    = out_valid && !out_ready;
            hold_re = p_re;
            hold_im = p_im;
            if (in_valid && in_ready) idx++;
            tick();
        end
        check("stream_count", 32'(got), 32'd8);
        check("stream_in_ready_dropped", 32'(saw_stall), 32'd1);

        // Asynchronous reset with three samples in flight (both widths).
        out_ready = 1'b0; in_valid = 1'b1;
        a_re = 16'sh2000; a_im = 16'sh1000; b_re = 16'sh1000; b_im = 16'sh2000;
        c_re = 12'sh400;  c_im = 12'sh200;  d_re = 12'sh200;  d_im = 12'sh400;
        repeat (5) tick();
        check("pre_rst_valid", 32'({out_valid, out_valid12}), 32'd3);
        check("pre_rst_im", 32'(p_im), 32'h0A00);
        check("pre_rst_im12", 32'(p_im12), 32'h280);
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'({out_valid, out_valid_t, out_valid12}), 32'd0);
        check("async_rst_p", 32'({p_re, p_im}), 32'd0);
        check("async_rst_p12", 32'({p_re12, p_im12}), 32'd0);
        check("async_rst_ovf", 32'({ovf, ovf_t, ovf12}), 32'd0);
        check("async_rst_in_ready", 32'({in_ready, in_ready_t, in_ready12}), 32'd7);
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("no_stale_%0d", i), 32'({out_valid, out_valid_t, out_valid12}), 32'd0);
        end

        // Q1.11 instance: (-1)(-1) then random samples against the model.
        send_one('0, '0, '0, '0, 12'sh800, 12'sh000, 12'sh800, 12'sh000, 1'b1, "w12_neg1");
        check("w12_neg1_re", 32'(p_re12), 32'h7FF);
        check("w12_neg1_im", 32'(p_im12), 32'h0);
        check("w12_neg1_ovf", 32'(ovf12), 32'd1);
        for (int i = 0; i < 6; i++) begin
            r_cr = 12'($urandom()); r_ci = 12'($urandom());
            r_dr = 12'($urandom()); r_di = 12'($urandom());
            x_re = 12'(fx_model(sx12(r_cr) * sx12(r_dr) - sx12(r_ci) * sx12(r_di), 12, 11, 1, cl_re));
            x_im = 12'(fx_model(sx12(r_cr) * sx12(r_di) + sx12(r_ci) * sx12(r_dr), 12, 11, 1, cl_im));
            send_one('0, '0, '0, '0, r_cr, r_ci, r_dr, r_di, 1'b1, $sformatf("w12_r%0d", i));
            check($sformatf("w12_r%0d_re", i), 32'(p_re12), 32'(x_re));
            check($sformatf("w12_r%0d_im", i), 32'(p_im12), 32'(x_im));
            check($sformatf("w12_r%0d_ovf", i), 32'(ovf12), 32'(cl_re | cl_im));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
